// File: rtl/pipe_track.sv
// In-order pipeline stage tracker with hold, flush and bubble insertion, a youngest-match
// forwarding lookup, and retire/bubble counters. Zero-latency lookup; a hold stalls the front.
module pipe_track #(
  parameter int          DEPTH = 4,
  parameter int          WIDTH = 32,
  parameter int          RD_W  = 5,
  parameter logic [WIDTH-1:0] NOP = 32'h00000013,
  localparam int         SW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [RD_W-1:0]        in_rd,
  input  logic                   in_wr,
  input  logic                   in_load,
  input  logic                   hold_en,
  input  logic [SW-1:0]          hold_stage,
  input  logic                   flush_en,
  input  logic [SW-1:0]          flush_stage,
  input  logic [RD_W-1:0]        q_rs,
  output logic                   fwd_hit,
  output logic [SW-1:0]          fwd_sel,
  output logic                   fwd_load,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [31:0]            retire_cnt,
  output logic [31:0]            bubble_cnt
);

  logic [DEPTH-1:0] vld_q, vld_d, wr_q, wr_d, ld_q, ld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [RD_W-1:0]  rd_q  [DEPTH];
  logic [RD_W-1:0]  rd_d  [DEPTH];
  logic [31:0]      retire_q, retire_d, bubble_q, bubble_d;

  // prv_* is what each stage would receive on a plain advance; slot 0 is the input bundle
  logic [DEPTH-1:0] prv_vld, prv_wr, prv_ld;
  logic [WIDTH-1:0] prv_dat [DEPTH];
  logic [RD_W-1:0]  prv_rd  [DEPTH];

  int   hs, fs;
  logic freeze;

  always_comb begin
    hs = (int'(hold_stage)  > DEPTH - 1) ? DEPTH - 1 : int'(hold_stage);
    fs = (int'(flush_stage) > DEPTH - 1) ? DEPTH - 1 : int'(flush_stage);
    freeze   = hold_en & ~flush_en & (hs == DEPTH - 1);
    in_ready = ~hold_en | flush_en;
  end

  always_comb begin
    prv_vld    = '0;
    prv_wr     = '0;
    prv_ld     = '0;
    prv_vld[0] = in_valid;
    prv_wr[0]  = in_valid & in_wr;
    prv_ld[0]  = in_valid & in_load;
    prv_dat[0] = in_valid ? in_data : NOP;
    prv_rd[0]  = in_valid ? in_rd : '0;
    for (int i = 1; i < DEPTH; i++) begin
      prv_vld[i] = vld_q[i-1];
      prv_wr[i]  = wr_q[i-1];
      prv_ld[i]  = ld_q[i-1];
      prv_dat[i] = dat_q[i-1];
      prv_rd[i]  = rd_q[i-1];
    end
  end

  always_comb begin
    vld_d    = vld_q;
    wr_d     = wr_q;
    ld_d     = ld_q;
    dat_d    = dat_q;
    rd_d     = rd_q;
    bubble_d = bubble_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_en) begin
        if (i <= fs) begin
          vld_d[i] = 1'b0;  wr_d[i] = 1'b0;  ld_d[i] = 1'b0;
          dat_d[i] = NOP;   rd_d[i] = '0;
          bubble_d = bubble_d + {31'd0, vld_q[i]};
        end else begin
          vld_d[i] = prv_vld[i];  wr_d[i] = prv_wr[i];  ld_d[i] = prv_ld[i];
          dat_d[i] = prv_dat[i];  rd_d[i] = prv_rd[i];
        end
      end else if (hold_en) begin
        if (i == hs + 1) begin
          vld_d[i] = 1'b0;  wr_d[i] = 1'b0;  ld_d[i] = 1'b0;
          dat_d[i] = NOP;   rd_d[i] = '0;
          bubble_d = bubble_d + 32'd1;
        end else if (i > hs + 1) begin
          vld_d[i] = prv_vld[i];  wr_d[i] = prv_wr[i];  ld_d[i] = prv_ld[i];
          dat_d[i] = prv_dat[i];  rd_d[i] = prv_rd[i];
        end
      end else begin
        vld_d[i] = prv_vld[i];  wr_d[i] = prv_wr[i];  ld_d[i] = prv_ld[i];
        dat_d[i] = prv_dat[i];  rd_d[i] = prv_rd[i];
      end
    end
    retire_d = retire_q + {31'd0, vld_q[DEPTH-1] & ~freeze};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_q     <= '0;
      ld_q     <= '0;
      retire_q <= '0;
      bubble_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= NOP;
        rd_q[i]  <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      wr_q     <= wr_d;
      ld_q     <= ld_d;
      dat_q    <= dat_d;
      rd_q     <= rd_d;
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_sel  = '0;
    fwd_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && wr_q[i] && (rd_q[i] == q_rs) && (q_rs != '0)) begin
        fwd_hit  = 1'b1;
        fwd_sel  = SW'(i);
        fwd_load = ld_q[i];
      end
    end
  end

  always_comb begin
    stage_data = '0;
    for (int i = 0; i < DEPTH; i++) stage_data[i*WIDTH +: WIDTH] = dat_q[i];
  end

  assign stage_valid = vld_q;
  assign out_valid   = vld_q[DEPTH-1];
  assign out_data    = dat_q[DEPTH-1];
  assign retire_cnt  = retire_q;
  assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_pipe_track.sv
// Directed bench for pipe_track (DEPTH=4): advance, hold, flush, priority, forwarding, reset, wrap.
module tb_pipe_track;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wr, in_load;
  logic [31:0] in_data;
  logic [4:0]  in_rd, q_rs;
  logic        hold_en, flush_en;
  logic [1:0]  hold_stage, flush_stage;
  logic        fwd_hit, fwd_load, out_valid;
  logic [1:0]  fwd_sel;
  logic [3:0]  stage_valid;
  logic [127:0] stage_data;
  logic [31:0] out_data, retire_cnt, bubble_cnt;

  int checks = 0;
  int failures = 0;

  pipe_track dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .in_wr(in_wr), .in_load(in_load),
    .hold_en(hold_en), .hold_stage(hold_stage), .flush_en(flush_en), .flush_stage(flush_stage),
    .q_rs(q_rs), .fwd_hit(fwd_hit), .fwd_sel(fwd_sel), .fwd_load(fwd_load),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd,
                       input logic wr, input logic ld);
    in_valid = v; in_data = d; in_rd = rd; in_wr = wr; in_load = ld;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    hold_en = 1'b0; hold_stage = 2'd0; flush_en = 1'b0; flush_stage = 2'd0; q_rs = 5'd0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] sd(input int i);
    return stage_data[i*32 +: 32];
  endfunction

  initial begin
    logic [31:0] pay [6];
    pay[0] = 32'hA0000001; pay[1] = 32'hB0000002; pay[2] = 32'hC0000003;
    pay[3] = 32'hD0000004; pay[4] = 32'hE0000005; pay[5] = 32'hF0000006;

    // Reset state
    do_reset();
    check("rst_valid",  {28'd0, stage_valid}, 32'h0);
    check("rst_out",    out_data, NOP);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_bubble", bubble_cnt, 32'd0);
    check("rst_ready",  {31'd0, in_ready}, 32'd1);

    // 1: six back-to-back instructions; A retires at cycle 4, F at cycle 9
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc <= 6) drive(1'b1, pay[cyc-1], 5'd1, 1'b1, 1'b0);
      else          drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      tick();
      if (cyc == 4) check("t1_outA", out_data, pay[0]);
      if (cyc == 9) check("t1_outF", out_data, pay[5]);
    end
    check("t1_retire", retire_cnt, 32'd6);
    check("t1_bubble", bubble_cnt, 32'd0);

    // 2: load x5 in stage 1, hold H=1
    do_reset();
    drive(1'b1, 32'h11110005, 5'd5, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h22220007, 5'd7, 1'b1, 1'b0); tick();
    q_rs = 5'd5; #1;
    check("t2_hit",  {31'd0, fwd_hit}, 32'd1);
    check("t2_sel",  {30'd0, fwd_sel}, 32'd1);
    check("t2_load", {31'd0, fwd_load}, 32'd1);
    drive(1'b1, 32'h33330009, 5'd9, 1'b1, 1'b0);
    hold_en = 1'b1; hold_stage = 2'd1; #1;
    check("t2_ready", {31'd0, in_ready}, 32'd0);
    tick();
    hold_en = 1'b0;
    check("t2_valid",  {28'd0, stage_valid}, 32'h3);
    check("t2_s0",     sd(0), 32'h22220007);
    check("t2_s1",     sd(1), 32'h11110005);
    check("t2_s2",     sd(2), NOP);
    check("t2_bubble", bubble_cnt, 32'd1);

    // 3: full pipe, flush F=1 with an input offered
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h50 + 32'(i), 5'd2, 1'b1, 1'b0); tick();
    end
    drive(1'b1, 32'h0000BEEF, 5'd4, 1'b1, 1'b0);
    flush_en = 1'b1; flush_stage = 2'd1; #1;
    check("t3_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush_en = 1'b0;
    check("t3_valid",  {28'd0, stage_valid}, 32'hC);
    check("t3_s0",     sd(0), NOP);
    check("t3_s2",     sd(2), 32'h52);
    check("t3_out",    out_data, 32'h51);
    check("t3_bubble", bubble_cnt, 32'd2);
    check("t3_retire", retire_cnt, 32'd1);

    // 4: flush F=0 and hold H=2 together, flush wins
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h70 + 32'(i), 5'd2, 1'b1, 1'b0); tick();
    end
    drive(1'b1, 32'h0000CAFE, 5'd4, 1'b1, 1'b0);
    flush_en = 1'b1; flush_stage = 2'd0; hold_en = 1'b1; hold_stage = 2'd2; #1;
    check("t4_ready", {31'd0, in_ready}, 32'd1);
    tick();
    flush_en = 1'b0; hold_en = 1'b0;
    check("t4_valid",  {28'd0, stage_valid}, 32'hE);
    check("t4_s1",     sd(1), 32'h73);
    check("t4_out",    out_data, 32'h71);
    check("t4_bubble", bubble_cnt, 32'd1);

    // 5: x3 in stages 1 and 3, x9 in stage 2, x0 writer in stage 0
    do_reset();
    drive(1'b1, 32'h00000301, 5'd3, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h00000902, 5'd9, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h00000303, 5'd3, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h00000004, 5'd0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    q_rs = 5'd3; #1;
    check("t5_hit3",  {31'd0, fwd_hit}, 32'd1);
    check("t5_sel3",  {30'd0, fwd_sel}, 32'd1);
    check("t5_load3", {31'd0, fwd_load}, 32'd0);
    q_rs = 5'd9; #1;
    check("t5_sel9",  {30'd0, fwd_sel}, 32'd2);
    q_rs = 5'd0; #1;
    check("t5_hit0",  {31'd0, fwd_hit}, 32'd0);
    check("t5_sel0",  {30'd0, fwd_sel}, 32'd0);
    // whole pipe frozen: nothing moves, nothing counted
    hold_en = 1'b1; hold_stage = 2'd3;
    tick();
    hold_en = 1'b0;
    check("t5_frz_out",    out_data, 32'h00000301);
    check("t5_frz_retire", retire_cnt, 32'd0);
    check("t5_frz_bubble", bubble_cnt, 32'd0);

    // 6: reset mid-stream takes effect immediately
    q_rs = 5'd3;
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("t6_valid",  {28'd0, stage_valid}, 32'h0);
    check("t6_out",    out_data, NOP);
    check("t6_retire", retire_cnt, 32'd0);
    check("t6_hit",    {31'd0, fwd_hit}, 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0000D00D, 5'd1, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("t6_outv", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    force dut.retire_q = 32'hFFFFFFFF;
    #1 release dut.retire_q;
    #1;
    check("t6_preload", retire_cnt, 32'hFFFFFFFF);
    tick();
    check("t6_wrap", retire_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
